// File: rtl/matrix_op_scheduler.sv
// Round-robin scheduler that shares one set of 2x2 matrix units between two requesters.
// Define MATRIX_SCHED_STATS_EN to add saturating response/error counters (stat_done, stat_err).

module matrix_adder_2x2 (
    input  logic [11:0] a_i,
    input  logic [11:0] b_i,
    output logic [15:0] c_o
);
    for (genvar i = 0; i < 4; i++) begin : g_el
        assign c_o[4*i +: 4] = {1'b0, a_i[3*i +: 3]} + {1'b0, b_i[3*i +: 3]};
    end
endmodule

module matrix_subtractor_2x2 (
    input  logic [11:0] a_i,
    input  logic [11:0] b_i,
    output logic [15:0] c_o
);
    for (genvar i = 0; i < 4; i++) begin : g_el
        assign c_o[4*i +: 4] = {1'b0, a_i[3*i +: 3]} - {1'b0, b_i[3*i +: 3]};
    end
endmodule

module matrix_multiply (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] c_o
);
    logic [3:0] a11, a12, a21, a22, b11, b12, b21, b22;
    assign {a11, a12, a21, a22} = {2'b0, a_i[7:6], 2'b0, a_i[5:4], 2'b0, a_i[3:2], 2'b0, a_i[1:0]};
    assign {b11, b12, b21, b22} = {2'b0, b_i[7:6], 2'b0, b_i[5:4], 2'b0, b_i[3:2], 2'b0, b_i[1:0]};
    // Each element is truncated to 4 bits (modulo 16).
    assign c_o = {a11 * b11 + a12 * b21, a11 * b12 + a12 * b22,
                  a21 * b11 + a22 * b21, a21 * b12 + a22 * b22};
endmodule

module matrix_transpose_2x2 (
    input  logic [11:0] a_i,
    output logic [15:0] t_o
);
    assign t_o = {1'b0, a_i[11:9], 1'b0, a_i[5:3], 1'b0, a_i[8:6], 1'b0, a_i[2:0]};
endmodule

module determinant_2x2 (
    input  logic [7:0] a_i,
    output logic [3:0] det_o
);
    logic [3:0] a11, a12, a21, a22;
    assign {a11, a12, a21, a22} = {2'b0, a_i[7:6], 2'b0, a_i[5:4], 2'b0, a_i[3:2], 2'b0, a_i[1:0]};
    assign det_o = a11 * a22 - a12 * a21;
endmodule

// Integer inverse: exists only when det is +1 or -1, in which case inv = det * adj(A).
module inverse_2x2 (
    input  logic [15:0] a_i,
    output logic [15:0] inv_o,
    output logic        valid_o
);
    logic [3:0] a11, a12, a21, a22;
    logic [8:0] det;
    assign {a11, a12, a21, a22} = a_i;
    assign det = {1'b0, {4'b0, a11} * {4'b0, a22}} - {1'b0, {4'b0, a12} * {4'b0, a21}};
    assign valid_o = (det == 9'd1) || (det == 9'h1FF);
    always_comb begin
        inv_o = '0;
        if (det == 9'd1)        inv_o = {a22, -a12, -a21, a11};
        else if (det == 9'h1FF) inv_o = {-a22, a12, a21, -a11};
    end
endmodule

module matrix_op_scheduler #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [11:0] req0_a,
    input  logic [11:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [11:0] req1_a,
    input  logic [11:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic        busy
`ifdef MATRIX_SCHED_STATS_EN
    ,
    output logic [15:0] stat_done,
    output logic [7:0]  stat_err
`endif
);
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : ((SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d, id_q, id_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [11:0] a_q, a_d, b_q, b_d;
    logic        rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        grant_valid, grant_id;

    logic [15:0] add_c, sub_c, mul_c, tr_c, inv_c;
    logic [3:0]  det_c;
    logic        inv_ok;
    logic [7:0]  a_lo, b_lo;

    assign a_lo = {a_q[10:9], a_q[7:6], a_q[4:3], a_q[1:0]};
    assign b_lo = {b_q[10:9], b_q[7:6], b_q[4:3], b_q[1:0]};

    matrix_adder_2x2      u_add (.a_i(a_q), .b_i(b_q), .c_o(add_c));
    matrix_subtractor_2x2 u_sub (.a_i(a_q), .b_i(b_q), .c_o(sub_c));
    matrix_multiply       u_mul (.a_i(a_lo), .b_i(b_lo), .c_o(mul_c));
    matrix_transpose_2x2  u_tr  (.a_i(a_q), .t_o(tr_c));
    determinant_2x2       u_det (.a_i(a_lo), .det_o(det_c));
    inverse_2x2           u_inv (.a_i({1'b0, a_q[11:9], 1'b0, a_q[8:6], 1'b0, a_q[5:3], 1'b0, a_q[2:0]}),
                                 .inv_o(inv_c), .valid_o(inv_ok));

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        grant_valid = 1'b0;
        grant_id    = ptr_q;
        if (state_q == S_IDLE) begin
            if (ptr_q ? req1_valid : req0_valid) begin
                grant_valid = 1'b1;
            end else if (ptr_q ? req0_valid : req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~ptr_q;
            end
        end
    end

    assign req0_ready = grant_valid && !grant_id;
    assign req1_ready = grant_valid && grant_id;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;
        unique case (state_q)
            S_IDLE: if (grant_valid) begin
                op_d    = grant_id ? req1_op : req0_op;
                a_d     = grant_id ? req1_a : req0_a;
                b_d     = grant_id ? req1_b : req0_b;
                id_d    = grant_id;
                ptr_d   = ~grant_id;
                cnt_d   = 5'(SETTLE_EFF + 1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    rsp_id_d   = id_q;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = '0;
                    case (op_q)
                        3'd0: rsp_data_d = add_c;
                        3'd1: rsp_data_d = sub_c;
                        3'd2: rsp_data_d = mul_c;
                        3'd3: rsp_data_d = tr_c;
                        3'd4: rsp_data_d = {12'h000, det_c};
                        3'd5: if (inv_ok) rsp_data_d = inv_c; else rsp_err_d = 1'b1;
                        default: rsp_err_d = 1'b1;
                    endcase
                    state_d = S_RESP;
                end
            end
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b0;
            id_q       <= 1'b0;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != S_IDLE);

`ifdef MATRIX_SCHED_STATS_EN
    logic [15:0] stat_done_q;
    logic [7:0]  stat_err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_done_q <= '0;
            stat_err_q  <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (stat_done_q != 16'hFFFF) stat_done_q <= stat_done_q + 16'd1;
            if (rsp_err_q && stat_err_q != 8'hFF) stat_err_q <= stat_err_q + 8'd1;
        end
    end
    assign stat_done = stat_done_q;
    assign stat_err  = stat_err_q;
`endif
endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Directed bench for matrix_op_scheduler: vector table plus arbitration, backpressure and reset sequences.
// Stats checks are compiled in when MATRIX_SCHED_STATS_EN is defined.

module tb_matrix_op_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [11:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [15:0] rsp_data;
`ifdef MATRIX_SCHED_STATS_EN
    logic [15:0] stat_done;
    logic [7:0]  stat_err;
`endif

    // Second instance with a longer settle time, used for latency and mid-EXEC reset.
    logic        rst4, v0_4, v1_4, r0_4, r1_4, rsp_valid4, rsp_ready4, rsp_id4, rsp_err4, busy4;
    logic [15:0] rsp_data4;
`ifdef MATRIX_SCHED_STATS_EN
    logic [15:0] stat_done4;
    logic [7:0]  stat_err4;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matrix_op_scheduler #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .busy(busy)
`ifdef MATRIX_SCHED_STATS_EN
        , .stat_done(stat_done), .stat_err(stat_err)
`endif
    );

    matrix_op_scheduler #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst4),
        .req0_valid(v0_4), .req0_ready(r0_4), .req0_op(3'd0), .req0_a(12'o3214), .req0_b(12'o1111),
        .req1_valid(v1_4), .req1_ready(r1_4), .req1_op(3'd0), .req1_a(12'o3214), .req1_b(12'o1111),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_id(rsp_id4), .rsp_err(rsp_err4),
        .rsp_data(rsp_data4), .busy(busy4)
`ifdef MATRIX_SCHED_STATS_EN
        , .stat_done(stat_done4), .stat_err(stat_err4)
`endif
    );

    typedef struct {
        logic        port;
        logic [2:0]  op;
        logic [11:0] a;
        logic [11:0] b;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int n;
        logic rdy;
        if (v.port) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end
        #1;
        n = 0;
        rdy = v.port ? req1_ready : req0_ready;
        while (!rdy && n < 20) begin
            @(posedge clk); #2; n++;
            rdy = v.port ? req1_ready : req0_ready;
        end
        check("grant", {31'b0, rdy}, 32'd1);
        check("other_ready_low", {31'b0, v.port ? req0_ready : req1_ready}, 32'd0);
        @(posedge clk); #1;
        // Drop valid and scramble operands: the latched command must be unaffected.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~v.a; req0_b = ~v.b; req0_op = ~v.op;
        req1_a = ~v.a; req1_b = ~v.b; req1_op = ~v.op;
        check("busy_exec", {31'b0, busy}, 32'd1);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("latency", n, 32'd2);
        check("rsp_data", {16'b0, rsp_data}, {16'b0, v.exp_data});
        check("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
        check("rsp_id", {31'b0, rsp_id}, {31'b0, v.port});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("idle_after_rsp", {30'b0, rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        int n;
        logic [15:0] held;
        vecs[0]  = '{1'b0, 3'd0, 12'o3214, 12'o1111, 16'h4325, 1'b0};
        vecs[1]  = '{1'b0, 3'd1, 12'o3214, 12'o1111, 16'h2103, 1'b0};
        vecs[2]  = '{1'b0, 3'd4, 12'o1233, 12'o0000, 16'h000D, 1'b0};
        vecs[3]  = '{1'b1, 3'd7, 12'o3214, 12'o1111, 16'h0000, 1'b1};
        vecs[4]  = '{1'b0, 3'd3, 12'o3214, 12'o0000, 16'h3124, 1'b0};
        vecs[5]  = '{1'b1, 3'd2, 12'o1230, 12'o1111, 16'h3333, 1'b0};
        vecs[6]  = '{1'b1, 3'd5, 12'o1111, 12'o0000, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 3'd5, 12'o2111, 12'o0000, 16'h1FF2, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 12'o7777, 12'o7777, 16'hEEEE, 1'b0};
        vecs[9]  = '{1'b0, 3'd1, 12'o0000, 12'o1111, 16'hFFFF, 1'b0};
        vecs[10] = '{1'b1, 3'd2, 12'o3333, 12'o3333, 16'h2222, 1'b0};
        vecs[11] = '{1'b0, 3'd2, 12'o7777, 12'o1111, 16'h6666, 1'b0};
        vecs[12] = '{1'b0, 3'd6, 12'o1234, 12'o4321, 16'h0000, 1'b1};
        vecs[13] = '{1'b1, 3'd4, 12'o3003, 12'o0000, 16'h0009, 1'b0};

        rst = 1'b1; rst4 = 1'b1; rsp_ready = 1'b0; rsp_ready4 = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; v0_4 = 1'b0; v1_4 = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0; req1_op = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst4 = 1'b0;
        check("reset_outputs", {rsp_valid, rsp_id, rsp_err, busy, rsp_data}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_cmd(vecs[i]);
`ifdef MATRIX_SCHED_STATS_EN
            if (i == 3) begin
                check("stat_done", {16'b0, stat_done}, 32'd4);
                check("stat_err", {24'b0, stat_err}, 32'd1);
            end
`endif
        end

        // Round-robin with both requesters continuously valid, starting from reset.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        req0_op = 3'd0; req0_a = 12'o3214; req0_b = 12'o1111;
        req1_op = 3'd0; req1_a = 12'o3214; req1_b = 12'o1111;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rr_first_grant", {30'b0, req0_ready, req1_ready}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!rsp_valid && n < 40) begin
                @(posedge clk); #1; n++;
            end
            check("rr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("rr_rsp_id", {31'b0, rsp_id}, k % 2);
            if (k == 0) begin
                held = rsp_data;
                check("rr_data", {16'b0, held}, 32'h4325);
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk); #1;
                    check("hold_stable", {rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready, rsp_data},
                          {6'b100100, held});
                end
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Longer settle time: latency, then reset in the middle of EXEC.
        v0_4 = 1'b1;
        @(posedge clk); #1;
        v0_4 = 1'b0;
        n = 0;
        while (!rsp_valid4 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("latency_s4", n, 32'd5);
        check("data_s4", {16'b0, rsp_data4}, 32'h4325);
        rsp_ready4 = 1'b1; @(posedge clk); #1; rsp_ready4 = 1'b0;

        v1_4 = 1'b1;
        @(posedge clk); #1;
        v1_4 = 1'b0;
        @(posedge clk); #1;
        check("s4_in_exec", {31'b0, busy4}, 32'd1);
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        check("rst_exec", {29'b0, rsp_valid4, busy4, rsp_err4}, 32'd0);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_valid4 || busy4) n++;
        end
        check("no_stale_rsp", n, 32'd0);
        v0_4 = 1'b1; v1_4 = 1'b1;
        #1;
        check("grant_after_rst", {30'b0, r0_4, r1_4}, 32'd2);
        v0_4 = 1'b0; v1_4 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
